ahb_bus_arbiter: RTL and testbench
==================================

// Module: ahb_bus_arbiter
// PURPOSE
//   Shares one AHB slave port between NUM_M bus masters, e.g. the LSU master and the fetch master.
//   Each master raises hbusreq and waits for hgrant.
//   The arbiter grants one master at a time in round-robin order and holds the grant for exactly one transfer.
//   It muxes that master's address, control and write data onto the slave side.
// PARAMETERS
//   NUM_M        2    number of masters, 2..4; index 0 has top priority after reset
//   TIMEOUT_CYC  16   grant-to-address watchdog limit in cycles (AHB_ARB_TIMEOUT_EN only)
// PORTS
//   clk              in   1         system clock, all logic on posedge
//   rstn             in   1         asynchronous active-low reset
//   hbusreq_m2h      in   NUM_M     per-master bus request
//   haddr_ctrl_m2h   in   NUM_M     per-master address-phase valid
//   hwrite_m2h       in   NUM_M     per-master write flag
//   haddr_m2h        in   32*NUM_M  per-master address, master i at [32*i+:32]
//   hwdata_m2h       in   32*NUM_M  per-master write data, same packing
//   hgrant_h2m       out  NUM_M     registered one-hot grant
//   hready_s2m       in   1         slave ready, ends the data phase
//   haddr_h2s        out  32        muxed address to slave
//   haddr_ctrl_h2s   out  1         muxed address-phase valid
//   hwrite_h2s       out  1         muxed write flag
//   hwdata_h2s       out  32        write data of the data-phase owner
//   hmaster          out  2         index of the current grant or data-phase owner
//   arb_timeout      out  1         1-cycle pulse when a grant is revoked (macro only, else tied 0)
// BEHAVIOUR
//   Reset values: hgrant_h2m=0, hmaster=0, rr_ptr=0, state=ARB_IDLE, arb_timeout=0.
//   haddr_ctrl_h2s and hwrite_h2s read 0 when no grant is held.
//   FSM states: ARB_IDLE, ARB_GRANT, ARB_DATA, ARB_REARB.
//   ARB_IDLE:  if any hbusreq, pick the first requester at or after rr_ptr (cyclic).
//              Register hgrant[i]=1 and hmaster=i; go to ARB_GRANT.
//   ARB_GRANT: wait for haddr_ctrl_m2h[hmaster]=1 (the address phase, exactly 1 cycle); go to ARB_DATA.
//              If hbusreq[hmaster] drops before the address phase: clear the grant, go to ARB_REARB.
//   ARB_DATA:  hgrant stays high; wait for hready_s2m=1.
//              On hready_s2m=1: clear hgrant, set rr_ptr=hmaster+1 (wraps at NUM_M), go to ARB_REARB.
//   ARB_REARB: exactly 1 cycle with all grants low, so a master looping back to its GRANT state cannot see a stale grant.
//              Then re-arbitrate as in ARB_IDLE in the same cycle, or go to ARB_IDLE if there are no requests.
//   Latency:   request to hgrant is 1 cycle from ARB_IDLE and 2 cycles after a completed transfer.
//   Fairness:  the last owner has lowest priority; with all NUM_M requesting, grants rotate 0,1,..,NUM_M-1,0.
//   Address mux: haddr_h2s, haddr_ctrl_h2s, hwrite_h2s come from master hmaster while hgrant is nonzero.
//   Write data: hwdata_h2s is master hmaster's hwdata in ARB_DATA; masters hold hwdata stable from request through data phase.
//   haddr_ctrl from a master not granted is ignored and never reaches the slave.
//   The hready_s2m level is ignored outside ARB_DATA.
//   Simultaneous events:
//     - A new request arriving on the completion cycle is considered in ARB_REARB, not earlier.
//     - A request deassert during ARB_DATA does not abort the transfer.
//   Reset mid-transfer: everything returns to reset values immediately and the slave sees haddr_ctrl_h2s=0.
//   NUM_M out of range 2..4 is a configuration error; an elaboration-time check is required.
// CONFIGURATION
//   AHB_ARB_TIMEOUT_EN defined:
//     - A counter starts at 0 on entry to ARB_GRANT.
//     - If TIMEOUT_CYC cycles pass with no address phase: clear the grant, pulse arb_timeout for 1 cycle,
//       set rr_ptr=hmaster+1, go to ARB_REARB.
//     - The counter is cleared in every other state.
//   AHB_ARB_TIMEOUT_EN undefined:
//     - No counter; ARB_GRANT waits indefinitely; arb_timeout is tied 0.
// TESTING
//   1. Single request: only M0 requests, read addr 0x0000_1000, hready on the 2nd data cycle
//      -> hgrant=01 one cycle after the request; haddr_h2s=0x1000 with haddr_ctrl_h2s=1 for 1 cycle;
//         grant drops on the hready cycle.
//   2. Contention: M0 and M1 request continuously, back-to-back writes
//      -> grants alternate 01,10,01,10, separated by one all-zero REARB cycle.
//      -> each hwdata_h2s matches its owner's hwdata (M0 0xAAAA_0000, M1 0x5555_0001).
//   3. Wait states: M1 write with hready low for 5 data cycles
//      -> hgrant=10 and hwdata_h2s held for all 5 cycles; M0 requesting meanwhile is granted only after REARB.
//   4. Withdrawn request: M0 granted, drops hbusreq before haddr_ctrl
//      -> grant cleared next cycle; M1, if requesting, is granted after REARB; no address reaches the slave.
//   5. Reset in data phase: assert rstn=0 mid-ARB_DATA
//      -> hgrant=0 and haddr_ctrl_h2s=0 asynchronously; after release, M0 wins first.
//   6. Timeout (macro on, TIMEOUT_CYC=16): M1 granted, never issues an address
//      -> arb_timeout pulses on cycle 16 of ARB_GRANT and the grant is revoked.
//      -> with the macro off, the grant stays held for 100+ cycles.

Source files
------------

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: round-robin arbiter sharing one AHB slave port among NUM_M masters.
// Latency: request->grant 1 cycle from idle, 2 cycles after a completed transfer (one REARB gap).
// Backpressure: hready_s2m low stretches the data phase; the grant is held until it rises.
//
// Optional feature macro: AHB_ARB_TIMEOUT_EN (grant-to-address watchdog, pulses arb_timeout).
//
// Ports:
//   clk, rstn                      clock, async active-low reset
//   hbusreq_m2h / haddr_ctrl_m2h   per-master request / address-phase valid
//   hwrite_m2h, haddr_m2h,
//   hwdata_m2h                     per-master write flag, address, write data (32b each, packed)
//   hgrant_h2m                     registered one-hot grant
//   hready_s2m                     slave ready, ends the data phase
//   haddr_h2s, haddr_ctrl_h2s,
//   hwrite_h2s, hwdata_h2s         muxed slave-side signals
//   hmaster                        current grant / data-phase owner
//   arb_timeout                    1-cycle pulse when a grant is revoked by the watchdog
module ahb_bus_arbiter #(
  parameter int NUM_M       = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_M-1:0]     hbusreq_m2h,
  input  logic [NUM_M-1:0]     haddr_ctrl_m2h,
  input  logic [NUM_M-1:0]     hwrite_m2h,
  input  logic [32*NUM_M-1:0]  haddr_m2h,
  input  logic [32*NUM_M-1:0]  hwdata_m2h,
  output logic [NUM_M-1:0]     hgrant_h2m,
  input  logic                 hready_s2m,
  output logic [31:0]          haddr_h2s,
  output logic                 haddr_ctrl_h2s,
  output logic                 hwrite_h2s,
  output logic [31:0]          hwdata_h2s,
  output logic [1:0]           hmaster,
  output logic                 arb_timeout
);

  if (NUM_M < 2 || NUM_M > 4) begin : g_num_m_check
    $error("ahb_bus_arbiter: NUM_M must be in 2..4");
  end

  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_DATA, ARB_REARB} arb_state_e;

  arb_state_e        state_q;
  logic [NUM_M-1:0]  hgrant_q;
  logic [1:0]        hmaster_q;
  logic [1:0]        rr_ptr_q;

  // Per-master inputs padded to 4 entries so a 2-bit index is always in range.
  logic [3:0]        req4;
  logic [3:0]        ctrl4;
  logic [3:0]        wr4;
  logic [3:0][31:0]  addr4;
  logic [3:0][31:0]  wdata4;

  always_comb begin
    req4   = '0;
    ctrl4  = '0;
    wr4    = '0;
    addr4  = '0;
    wdata4 = '0;
    for (int i = 0; i < NUM_M; i++) begin
      req4[i]   = hbusreq_m2h[i];
      ctrl4[i]  = haddr_ctrl_m2h[i];
      wr4[i]    = hwrite_m2h[i];
      addr4[i]  = haddr_m2h[32*i +: 32];
      wdata4[i] = hwdata_m2h[32*i +: 32];
    end
  end

  // First requester at or after rr_ptr, searched cyclically.
  logic       pick_vld_d;
  logic [1:0] pick_d;
  logic [2:0] idx;

  always_comb begin
    pick_vld_d = 1'b0;
    pick_d     = '0;
    idx        = '0;
    for (int k = 0; k < NUM_M; k++) begin
      idx = {1'b0, rr_ptr_q} + 3'(k);
      if (idx >= 3'(NUM_M)) idx = idx - 3'(NUM_M);
      if (!pick_vld_d && req4[idx[1:0]]) begin
        pick_vld_d = 1'b1;
        pick_d     = idx[1:0];
      end
    end
  end

  logic [NUM_M-1:0] grant_onehot_d;
  logic [1:0]       rr_next_d;

  assign grant_onehot_d = {{(NUM_M-1){1'b0}}, 1'b1} << pick_d;
  // The last owner drops to lowest priority.
  assign rr_next_d = (hmaster_q == 2'(NUM_M-1)) ? 2'd0 : hmaster_q + 2'd1;

`ifdef AHB_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             arb_timeout_q;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ARB_IDLE;
      hgrant_q      <= '0;
      hmaster_q     <= '0;
      rr_ptr_q      <= '0;
`ifdef AHB_ARB_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      arb_timeout_q <= 1'b0;
`endif
    end else begin
`ifdef AHB_ARB_TIMEOUT_EN
      // Counter only advances while waiting in ARB_GRANT; zero everywhere else.
      tmo_cnt_q     <= '0;
      arb_timeout_q <= 1'b0;
`endif
      case (state_q)
        // ARB_REARB entry already cleared the grant, so this cycle shows all-zero.
        ARB_IDLE, ARB_REARB: begin
          if (pick_vld_d) begin
            hgrant_q  <= grant_onehot_d;
            hmaster_q <= pick_d;
            state_q   <= ARB_GRANT;
          end else begin
            state_q   <= ARB_IDLE;
          end
        end
        ARB_GRANT: begin
          if (ctrl4[hmaster_q]) begin
            state_q  <= ARB_DATA;
          end else if (!req4[hmaster_q]) begin
            hgrant_q <= '0;
            state_q  <= ARB_REARB;
          end
`ifdef AHB_ARB_TIMEOUT_EN
          else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            hgrant_q      <= '0;
            arb_timeout_q <= 1'b1;
            rr_ptr_q      <= rr_next_d;
            state_q       <= ARB_REARB;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
`endif
        end
        ARB_DATA: begin
          // Request deassert here is ignored: the transfer always completes.
          if (hready_s2m) begin
            hgrant_q <= '0;
            rr_ptr_q <= rr_next_d;
            state_q  <= ARB_REARB;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  logic grant_any;
  assign grant_any = |hgrant_q;

  assign hgrant_h2m     = hgrant_q;
  assign hmaster        = hmaster_q;
  assign haddr_h2s      = grant_any ? addr4[hmaster_q] : 32'h0;
  // Only the owner's single address phase in ARB_GRANT reaches the slave.
  assign haddr_ctrl_h2s = grant_any && (state_q == ARB_GRANT) && ctrl4[hmaster_q];
  assign hwrite_h2s     = grant_any ? wr4[hmaster_q] : 1'b0;
  assign hwdata_h2s     = (state_q == ARB_DATA) ? wdata4[hmaster_q] : 32'h0;

`ifdef AHB_ARB_TIMEOUT_EN
  assign arb_timeout = arb_timeout_q;
`else
  assign arb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter: directed self-checking bench for ahb_bus_arbiter (NUM_M=2).
// Latency: n/a (testbench).
// Backpressure: drives hready_s2m low to exercise wait states.
module tb_ahb_bus_arbiter;

  logic        clk;
  logic        rstn;
  logic [1:0]  hbusreq_m2h;
  logic [1:0]  haddr_ctrl_m2h;
  logic [1:0]  hwrite_m2h;
  logic [63:0] haddr_m2h;
  logic [63:0] hwdata_m2h;
  logic [1:0]  hgrant_h2m;
  logic        hready_s2m;
  logic [31:0] haddr_h2s;
  logic        haddr_ctrl_h2s;
  logic        hwrite_h2s;
  logic [31:0] hwdata_h2s;
  logic [1:0]  hmaster;
  logic        arb_timeout;

  int n_checks = 0;
  int n_pass   = 0;

  ahb_bus_arbiter #(.NUM_M(2), .TIMEOUT_CYC(16)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .hbusreq_m2h    (hbusreq_m2h),
    .haddr_ctrl_m2h (haddr_ctrl_m2h),
    .hwrite_m2h     (hwrite_m2h),
    .haddr_m2h      (haddr_m2h),
    .hwdata_m2h     (hwdata_m2h),
    .hgrant_h2m     (hgrant_h2m),
    .hready_s2m     (hready_s2m),
    .haddr_h2s      (haddr_h2s),
    .haddr_ctrl_h2s (haddr_ctrl_h2s),
    .hwrite_h2s     (hwrite_h2s),
    .hwdata_h2s     (hwdata_h2s),
    .hmaster        (hmaster),
    .arb_timeout    (arb_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    hbusreq_m2h    = '0;
    haddr_ctrl_m2h = '0;
    hwrite_m2h     = '0;
    hready_s2m     = 1'b0;
    rstn           = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    haddr_m2h  = {32'h0000_2000, 32'h0000_1000};
    hwdata_m2h = '0;
    do_reset();
    n_checks++; if (hgrant_h2m !== 2'b00) $display("FAIL reset_grant: got %b want 00", hgrant_h2m); else n_pass++;
    n_checks++; if (hmaster !== 2'd0) $display("FAIL reset_hmaster: got %0d want 0", hmaster); else n_pass++;
    n_checks++; if (haddr_ctrl_h2s !== 1'b0 || hwrite_h2s !== 1'b0)
      $display("FAIL reset_ctrl: got ctrl=%b wr=%b want 0 0", haddr_ctrl_h2s, hwrite_h2s); else n_pass++;
    n_checks++; if (arb_timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", arb_timeout); else n_pass++;
  endtask

  task automatic test_single();
    haddr_m2h[31:0] = 32'h0000_1000;
    hwrite_m2h      = 2'b00;
    hbusreq_m2h     = 2'b01;
    tick();
    n_checks++; if (hgrant_h2m !== 2'b01) $display("FAIL single_grant: got %b want 01", hgrant_h2m); else n_pass++;
    haddr_ctrl_m2h = 2'b01;
    #1;
    n_checks++; if (haddr_h2s !== 32'h0000_1000 || haddr_ctrl_h2s !== 1'b1)
      $display("FAIL single_addr: got %h/%b want 00001000/1", haddr_h2s, haddr_ctrl_h2s); else n_pass++;
    tick();
    haddr_ctrl_m2h = 2'b00;
    #1;
    n_checks++; if (haddr_ctrl_h2s !== 1'b0 || hgrant_h2m !== 2'b01)
      $display("FAIL single_data1: got ctrl=%b grant=%b want 0 01", haddr_ctrl_h2s, hgrant_h2m); else n_pass++;
    tick();
    hready_s2m  = 1'b1;
    hbusreq_m2h = 2'b00;
    n_checks++; if (hgrant_h2m !== 2'b01) $display("FAIL single_data2: got %b want 01", hgrant_h2m); else n_pass++;
    tick();
    hready_s2m = 1'b0;
    n_checks++; if (hgrant_h2m !== 2'b00) $display("FAIL single_release: got %b want 00", hgrant_h2m); else n_pass++;
  endtask

  task automatic test_contention();
    logic [1:0]  exp_g;
    logic [31:0] exp_d;
    do_reset();
    haddr_m2h   = {32'h0000_B000, 32'h0000_A000};
    hwdata_m2h  = {32'h5555_0001, 32'hAAAA_0000};
    hwrite_m2h  = 2'b11;
    hbusreq_m2h = 2'b11;
    tick();
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_d = (k % 2 == 0) ? 32'hAAAA_0000 : 32'h5555_0001;
      n_checks++; if (hgrant_h2m !== exp_g) $display("FAIL cont_grant%0d: got %b want %b", k, hgrant_h2m, exp_g); else n_pass++;
      haddr_ctrl_m2h = exp_g;
      #1;
      n_checks++; if (haddr_ctrl_h2s !== 1'b1 || hwrite_h2s !== 1'b1)
        $display("FAIL cont_addr%0d: got ctrl=%b wr=%b want 1 1", k, haddr_ctrl_h2s, hwrite_h2s); else n_pass++;
      tick();
      haddr_ctrl_m2h = 2'b00;
      hready_s2m     = 1'b1;
      #1;
      n_checks++; if (hwdata_h2s !== exp_d) $display("FAIL cont_wdata%0d: got %h want %h", k, hwdata_h2s, exp_d); else n_pass++;
      tick();
      hready_s2m = 1'b0;
      if (k == 3) hbusreq_m2h = 2'b00;
      n_checks++; if (hgrant_h2m !== 2'b00) $display("FAIL cont_rearb%0d: got %b want 00", k, hgrant_h2m); else n_pass++;
      tick();
    end
  endtask

  task automatic test_wait_states();
    hwdata_m2h[63:32] = 32'h1234_5678;
    hwrite_m2h        = 2'b10;
    hbusreq_m2h       = 2'b10;
    tick();
    n_checks++; if (hgrant_h2m !== 2'b10) $display("FAIL wait_grant: got %b want 10", hgrant_h2m); else n_pass++;
    hbusreq_m2h    = 2'b11;
    haddr_ctrl_m2h = 2'b10;
    tick();
    haddr_ctrl_m2h = 2'b00;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (hgrant_h2m !== 2'b10 || hwdata_h2s !== 32'h1234_5678)
        $display("FAIL wait_hold%0d: got grant=%b data=%h want 10 12345678", c, hgrant_h2m, hwdata_h2s); else n_pass++;
      tick();
    end
    hready_s2m = 1'b1;
    tick();
    hready_s2m  = 1'b0;
    hbusreq_m2h = 2'b01;
    n_checks++; if (hgrant_h2m !== 2'b00) $display("FAIL wait_rearb: got %b want 00", hgrant_h2m); else n_pass++;
    tick();
    n_checks++; if (hgrant_h2m !== 2'b01) $display("FAIL wait_m0_grant: got %b want 01", hgrant_h2m); else n_pass++;
    haddr_ctrl_m2h = 2'b01;
    tick();
    haddr_ctrl_m2h = 2'b00;
    hready_s2m     = 1'b1;
    hbusreq_m2h    = 2'b00;
    tick();
    hready_s2m = 1'b0;
    tick();
  endtask

  task automatic test_withdraw();
    do_reset();
    hbusreq_m2h = 2'b11;
    tick();
    n_checks++; if (hgrant_h2m !== 2'b01) $display("FAIL wd_grant: got %b want 01", hgrant_h2m); else n_pass++;
    hbusreq_m2h    = 2'b10;
    haddr_ctrl_m2h = 2'b10;   // ungranted master's address phase must be ignored
    #1;
    n_checks++; if (haddr_ctrl_h2s !== 1'b0) $display("FAIL wd_ignore: got %b want 0", haddr_ctrl_h2s); else n_pass++;
    tick();
    haddr_ctrl_m2h = 2'b00;
    n_checks++; if (hgrant_h2m !== 2'b00 || haddr_ctrl_h2s !== 1'b0)
      $display("FAIL wd_clear: got grant=%b ctrl=%b want 00 0", hgrant_h2m, haddr_ctrl_h2s); else n_pass++;
    tick();
    n_checks++; if (hgrant_h2m !== 2'b10) $display("FAIL wd_m1_grant: got %b want 10", hgrant_h2m); else n_pass++;
    haddr_ctrl_m2h = 2'b10;
    tick();
    haddr_ctrl_m2h = 2'b00;
    hready_s2m     = 1'b1;
    hbusreq_m2h    = 2'b00;
    tick();
    hready_s2m = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    hbusreq_m2h = 2'b10;
    tick();
    haddr_ctrl_m2h = 2'b10;
    tick();
    haddr_ctrl_m2h = 2'b10;   // keep driving to show nothing leaks after reset
    #2;
    rstn = 1'b0;
    #1;
    n_checks++; if (hgrant_h2m !== 2'b00 || haddr_ctrl_h2s !== 1'b0 || hmaster !== 2'd0)
      $display("FAIL rst_mid: got grant=%b ctrl=%b hm=%0d want 00 0 0", hgrant_h2m, haddr_ctrl_h2s, hmaster); else n_pass++;
    haddr_ctrl_m2h = 2'b00;
    hbusreq_m2h    = 2'b11;
    tick();
    rstn = 1'b1;
    tick();
    n_checks++; if (hgrant_h2m !== 2'b01) $display("FAIL rst_m0_first: got %b want 01", hgrant_h2m); else n_pass++;
    haddr_ctrl_m2h = 2'b01;
    tick();
    haddr_ctrl_m2h = 2'b00;
    hready_s2m     = 1'b1;
    hbusreq_m2h    = 2'b00;
    tick();
    hready_s2m = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int bad;
    hbusreq_m2h = 2'b10;
    tick();
    n_checks++; if (hgrant_h2m !== 2'b10) $display("FAIL tmo_grant: got %b want 10", hgrant_h2m); else n_pass++;
`ifdef AHB_ARB_TIMEOUT_EN
    bad = 0;
    for (int c = 2; c <= 16; c++) begin
      tick();
      if (hgrant_h2m !== 2'b10 || arb_timeout !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL tmo_hold: got %0d bad cycles want 0", bad); else n_pass++;
    tick();
    n_checks++; if (arb_timeout !== 1'b1 || hgrant_h2m !== 2'b00)
      $display("FAIL tmo_fire: got pulse=%b grant=%b want 1 00", arb_timeout, hgrant_h2m); else n_pass++;
    hbusreq_m2h = 2'b00;
    tick();
    n_checks++; if (arb_timeout !== 1'b0) $display("FAIL tmo_pulse_len: got %b want 0", arb_timeout); else n_pass++;
`else
    bad = 0;
    for (int c = 0; c < 110; c++) begin
      tick();
      if (hgrant_h2m !== 2'b10 || arb_timeout !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL tmo_held: got %0d bad cycles want 0", bad); else n_pass++;
    hbusreq_m2h = 2'b00;
    tick();
    n_checks++; if (hgrant_h2m !== 2'b00) $display("FAIL tmo_drop: got %b want 00", hgrant_h2m); else n_pass++;
`endif
    tick();
  endtask

  initial begin
    rstn = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_wait_states();
    test_withdraw();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
